chess_game_ctrl: RTL

Game-sequencing FSM for the chess timer. It sits between the push-button/switch front end and the two countdown counters. It decides which player's counter runs, reloads both counters with the selected time, and handles pause/resume. It also detects flag fall, counts moves per player and drives a buzzer pulse at game end. It replaces the purely combinational enable/reset steering with a registered controller.

---
 rtl/chess_game_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/chess_game_ctrl.sv
// Chess timer game sequencer: chooses the running clock, reloads both counters,
// handles pause/resume, flag fall, per-player move counts and the end-of-game buzzer.
module chess_game_ctrl #(
  parameter int unsigned MOVE_W   = 8,
  parameter int unsigned LOCKOUT  = 4,
  parameter int unsigned BUZZ_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              clear,
  input  logic              btn_p1,
  input  logic              btn_p2,
  input  logic [5:0]        time_sel,
  input  logic              zero1,
  input  logic              zero2,
  output logic              enable1,
  output logic              enable2,
  output logic              load,
  output logic              turn,
  output logic              flag1,
  output logic              flag2,
  output logic [MOVE_W-1:0] moves1,
  output logic [MOVE_W-1:0] moves2,
  output logic              buzzer,
  output logic [2:0]        state
);

  localparam int unsigned LOCK_W = (LOCKOUT < 1) ? 1 : $clog2(LOCKOUT + 1);
  localparam int unsigned BUZZ_W = (BUZZ_LEN < 2) ? 1 : $clog2(BUZZ_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN_P1 = 3'd1,
    S_RUN_P2 = 3'd2,
    S_PAUSED = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_enable1;
  logic                r_enable2;
  logic                r_load;
  logic                r_turn;
  logic                r_flag1;
  logic                r_flag2;
  logic [MOVE_W-1:0]   r_moves1;
  logic [MOVE_W-1:0]   r_moves2;
  logic                r_buzzer;
  logic [LOCK_W-1:0]   r_lock;
  logic [BUZZ_W-1:0]   r_buzz_cnt;
  logic                w_abort;

  // Anything that lands in IDLE: clear from PAUSED/OVER or an illegal state code.
  assign w_abort = (clear && (r_state == S_PAUSED || r_state == S_OVER)) ||
                   !(r_state inside {S_IDLE, S_RUN_P1, S_RUN_P2, S_PAUSED, S_OVER});

  always_ff @(posedge clk) begin
    if (reset || w_abort) begin
      r_state    <= S_IDLE;
      r_enable1  <= 1'b0;
      r_enable2  <= 1'b0;
      r_load     <= 1'b1;
      r_turn     <= 1'b0;
      r_flag1    <= 1'b0;
      r_flag2    <= 1'b0;
      r_moves1   <= '0;
      r_moves2   <= '0;
      r_buzzer   <= 1'b0;
      r_lock     <= '0;
      r_buzz_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && time_sel != 6'd0) begin
            r_state   <= S_RUN_P1;
            r_load    <= 1'b0;
            r_enable1 <= 1'b1;
            r_turn    <= 1'b0;
            r_lock    <= LOCK_W'(LOCKOUT);
          end
        end

        S_RUN_P1: begin
          if (r_lock != '0) r_lock <= r_lock - LOCK_W'(1);
          if (zero1) begin
            r_state    <= S_OVER;
            r_flag1    <= 1'b1;
            r_enable1  <= 1'b0;
            r_buzzer   <= (BUZZ_LEN != 0);
            r_buzz_cnt <= (BUZZ_LEN != 0) ? BUZZ_W'(BUZZ_LEN - 1) : '0;
          end else if (btn_p1 && r_lock == '0) begin
            r_state   <= S_RUN_P2;
            r_turn    <= 1'b1;
            r_enable1 <= 1'b0;
            r_enable2 <= 1'b1;
            r_lock    <= LOCK_W'(LOCKOUT);
            if (r_moves1 != '1) r_moves1 <= r_moves1 + MOVE_W'(1);
          end else if (pause) begin
            r_state   <= S_PAUSED;
            r_enable1 <= 1'b0;
          end
        end

        S_RUN_P2: begin
          if (r_lock != '0) r_lock <= r_lock - LOCK_W'(1);
          if (zero2) begin
            r_state    <= S_OVER;
            r_flag2    <= 1'b1;
            r_enable2  <= 1'b0;
            r_buzzer   <= (BUZZ_LEN != 0);
            r_buzz_cnt <= (BUZZ_LEN != 0) ? BUZZ_W'(BUZZ_LEN - 1) : '0;
          end else if (btn_p2 && r_lock == '0) begin
            r_state   <= S_RUN_P1;
            r_turn    <= 1'b0;
            r_enable2 <= 1'b0;
            r_enable1 <= 1'b1;
            r_lock    <= LOCK_W'(LOCKOUT);
            if (r_moves2 != '1) r_moves2 <= r_moves2 + MOVE_W'(1);
          end else if (pause) begin
            r_state   <= S_PAUSED;
            r_enable2 <= 1'b0;
          end
        end

        // Resume returns to whoever was on move; the lockout keeps its remaining count.
        S_PAUSED: begin
          if (start) begin
            r_state   <= r_turn ? S_RUN_P2 : S_RUN_P1;
            r_enable1 <= ~r_turn;
            r_enable2 <= r_turn;
          end
        end

        // Buzzer stays high while the down-counter is nonzero, giving BUZZ_LEN cycles in total.
        S_OVER: begin
          r_buzzer <= (r_buzz_cnt != '0);
          if (r_buzz_cnt != '0) r_buzz_cnt <= r_buzz_cnt - BUZZ_W'(1);
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign enable1 = r_enable1;
  assign enable2 = r_enable2;
  assign load    = r_load;
  assign turn    = r_turn;
  assign flag1   = r_flag1;
  assign flag2   = r_flag2;
  assign moves1  = r_moves1;
  assign moves2  = r_moves2;
  assign buzzer  = r_buzzer;
  assign state   = r_state;

endmodule
